vga_timing_gen: RTL



---
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
// Pixel-side bundle of the VGA timing generator: renderer handshake
// (enable, px_en, counters, pixel return) plus the DAC/connector pins.
interface vga_timing_gen_if;
  logic       enable;
  logic [7:0] pixel_in;
  logic       px_en;
  logic [9:0] h_pos;
  logic [9:0] v_pos;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;

  // Timing generator side.
  modport master (
    input  enable, pixel_in,
    output px_en, h_pos, v_pos, frame_start, hsync, vsync, vga_r, vga_g, vga_b
  );

  // Renderer / board side.
  modport slave (
    output enable, pixel_in,
    input  px_en, h_pos, v_pos, frame_start, hsync, vsync, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing generator. Counts the raster, decodes the display
// enable and syncs one cycle later, then re-aligns syncs and blanking to
// the renderer's returned pixel through a PIXEL_LATENCY-deep delay line.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FRONT       = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BACK        = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FRONT       = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BACK        = 33,
  parameter bit          SYNC_POL      = 1'b0,
  parameter int unsigned PIXEL_LATENCY = 1
) (
  input  logic             px_clk,
  input  logic             reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last counter value of each region; the FSMs leave a region on these.
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {HST_ACTIVE, HST_FRONT, HST_SYNC, HST_BACK} h_state_e;
  typedef enum logic [1:0] {VST_ACTIVE, VST_FRONT, VST_SYNC, VST_BACK} v_state_e;

  logic [9:0] h_cnt, v_cnt;
  logic       h_wrap, v_wrap;
  h_state_e   h_state, h_state_d;
  v_state_e   v_state, v_state_d;

  // Decoded raw syncs, active-high internally; polarity applied at the pins.
  logic hs_raw, vs_raw;

  logic [PIXEL_LATENCY-1:0] blank_dly, hs_dly, vs_dly;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Raster counters; enable low parks the raster at the frame origin.
  always_ff @(posedge px_clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!bus.enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Horizontal and vertical region state registers.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      h_state <= HST_ACTIVE;
      v_state <= VST_ACTIVE;
    end else begin
      h_state <= h_state_d;
      v_state <= v_state_d;
    end
  end

  // Region transitions; vertical regions only move on the line wrap.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed
    // branch in combinational logic would otherwise infer a latch.
    h_state_d = h_state;
    v_state_d = v_state;
    if (!bus.enable) begin
      h_state_d = HST_ACTIVE;
      v_state_d = VST_ACTIVE;
    end else begin
      case (h_state)
        HST_ACTIVE: if (h_cnt == H_ACT_END)  h_state_d = HST_FRONT;
        HST_FRONT:  if (h_cnt == H_FP_END)   h_state_d = HST_SYNC;
        HST_SYNC:   if (h_cnt == H_SYNC_END) h_state_d = HST_BACK;
        HST_BACK:   if (h_wrap)              h_state_d = HST_ACTIVE;
        default:                             h_state_d = HST_ACTIVE;
      endcase
      if (h_wrap) begin
        case (v_state)
          VST_ACTIVE: if (v_cnt == V_ACT_END)  v_state_d = VST_FRONT;
          VST_FRONT:  if (v_cnt == V_FP_END)   v_state_d = VST_SYNC;
          VST_SYNC:   if (v_cnt == V_SYNC_END) v_state_d = VST_BACK;
          VST_BACK:   if (v_wrap)              v_state_d = VST_ACTIVE;
          default:                             v_state_d = VST_ACTIVE;
        endcase
      end
    end
  end

  // Registered decode of the current raster position for the renderer.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset || !bus.enable) begin
      bus.px_en       <= 1'b0;
      bus.h_pos       <= '0;
      bus.v_pos       <= '0;
      bus.frame_start <= 1'b0;
      hs_raw          <= 1'b0;
      vs_raw          <= 1'b0;
    end else begin
      bus.px_en       <= (h_state == HST_ACTIVE) && (v_state == VST_ACTIVE);
      bus.h_pos       <= h_cnt;
      bus.v_pos       <= v_cnt;
      bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
      hs_raw          <= (h_state == HST_SYNC);
      vs_raw          <= (v_state == VST_SYNC);
    end
  end

  // Delay blank and syncs by the renderer's pixel latency; keeps shifting
  // while disabled so the pins drain to blank/inactive on their own.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      blank_dly <= '1;
      hs_dly    <= '0;
      vs_dly    <= '0;
    end else begin
      blank_dly[0] <= ~bus.px_en;
      hs_dly[0]    <= hs_raw;
      vs_dly[0]    <= vs_raw;
      for (int unsigned i = 1; i < PIXEL_LATENCY; i++) begin
        blank_dly[i] <= blank_dly[i-1];
        hs_dly[i]    <= hs_dly[i-1];
        vs_dly[i]    <= vs_dly[i-1];
      end
    end
  end

  // Pin registers: RGB, hsync and vsync all change on the same edge.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      {bus.vga_r, bus.vga_g, bus.vga_b} <= 8'h00;
      bus.hsync <= ~SYNC_POL;
      bus.vsync <= ~SYNC_POL;
    end else begin
      {bus.vga_r, bus.vga_g, bus.vga_b} <= blank_dly[PIXEL_LATENCY-1] ? 8'h00 : bus.pixel_in;
      bus.hsync <= hs_dly[PIXEL_LATENCY-1] ? SYNC_POL : ~SYNC_POL;
      bus.vsync <= vs_dly[PIXEL_LATENCY-1] ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule
